running_enemy_sprite_fetch: RTL and testbench
=============================================

// Module: running_enemy_sprite_fetch
// PURPOSE
//  Upstream stage of the running-enemy palette lookup.
//  - Per VGA pixel: tests whether (DrawX,DrawY) falls inside the enemy sprite box.
//  - Advances the run-cycle animation frame and forms the sprite ROM address.
//  - Aligns the ROM's 3-bit colour index with a hit flag. pal_index drives the palette's index input.
//  - Index 0 is the green chroma key (treated as transparent).
// PARAMETERS
//  SPR_W        32  sprite width, pixels
//  SPR_H        48  sprite height, pixels
//  NUM_FRAMES   6   run-cycle frames stored back to back in ROM
//  FRAME_TICKS  6   video frames per animation step
//  ROM_LATENCY  1   sprite ROM read latency, cycles (>=1)
//  localparam ADDR_W = $clog2(NUM_FRAMES*SPR_W*SPR_H)  (14 at defaults)
// PORTS
//  Clk           in   1       pixel-domain clock
//  Reset         in   1       asynchronous, active-high reset
//  frame_start   in   1       one-cycle pulse per video frame (vsync edge)
//  enemy_active  in   1       enemy alive and on screen
//  enemy_x       in   10      sprite top-left X
//  enemy_y       in   10      sprite top-left Y
//  facing_left   in   1       mirror sprite horizontally
//  DrawX         in   10      current pixel X
//  DrawY         in   10      current pixel Y
//  rom_addr      out  ADDR_W  sprite ROM read address (registered)
//  rom_q         in   3       ROM data, valid ROM_LATENCY cycles after rom_addr
//  pal_index     out  3       colour index to palette (registered)
//  pixel_on      out  1       enemy pixel opaque at aligned position (registered)
//  anim_frame    out  3       current animation frame 0..NUM_FRAMES-1
// BEHAVIOUR
//  Reset (async): rom_addr=0, pal_index=0, pixel_on=0, anim_frame=0, tick counter=0, hit pipeline cleared.
//  Animation:
//  - tick_cnt increments on frame_start.
//  - At FRAME_TICKS-1 plus frame_start: tick_cnt->0 and anim_frame increments, wrapping NUM_FRAMES-1 -> 0.
//  - enemy_active=0: tick_cnt and anim_frame held at 0. This wins over a coincident frame_start.
//  Stage 0 (comb, cycle n):
//  - lx = DrawX-enemy_x and ly = DrawY-enemy_y, computed 11-bit signed.
//  - hit = enemy_active & 0<=lx<SPR_W & 0<=ly<SPR_H.
//  - Flip: lx' = SPR_W-1-lx when flip enabled and facing_left, else lx' = lx.
//  Stage 1 (cycle n+1):
//  - rom_addr <= anim_frame*SPR_W*SPR_H + ly*SPR_W + lx'.
//  - rom_addr is only updated when hit=1; otherwise it holds its value.
//  - hit is delayed through a ROM_LATENCY+1 shift register.
//  Output (cycle n+ROM_LATENCY+2, i.e. 3 at defaults):
//  - pal_index <= hit_d ? rom_q : 0.
//  - pixel_on <= hit_d & (rom_q != 0).
//  - Latency is fixed and independent of hit, so the downstream DrawX compensation is constant.
//  Boundaries:
//  - Sprite box extending past X=639/Y=479: off-screen pixels are never drawn, no wrap.
//  - enemy_x/y > DrawX/DrawY yields negative lx/ly, hence hit=0.
//  - anim_frame change mid-scanline takes effect from the next stage-0 pixel. No tearing guard; frame_start arrives in blanking.
//  - Reset mid-line: outputs 0 the same cycle; the pipeline refills with valid data after latency.
// CONFIGURATION
//  RUNNING_ENEMY_FLIP_EN
//  - Defined: facing_left mirrors lx as above.
//  - Undefined: facing_left is ignored (port kept, unconnected internally) and lx' = lx always.
// TESTING
//  Common setup unless stated: enemy_x=100, enemy_y=200, enemy_active=1.
//  1 Reset: assert Reset mid-stream -> pal_index=0, pixel_on=0, anim_frame=0, rom_addr=0 immediately.
//  2 Address, anim_frame=0: DrawX=105, DrawY=203 -> rom_addr=101 at n+1; pal_index=rom_q at n+3.
//  3 Flip (RUNNING_ENEMY_FLIP_EN defined): same pixel with facing_left=1 -> rom_addr=122.
//    Same pixel, macro undefined -> rom_addr=101.
//  4 Animation: 12 frame_start pulses -> anim_frame=2.
//    Pixel (100,200) -> rom_addr=3072.
//    36 pulses -> anim_frame wraps to 0.
//    enemy_active=0 -> anim_frame=0.
//  5 Transparency/box:
//    - rom_q=0 inside box -> pixel_on=0, pal_index=0.
//    - DrawX=132 (lx=32) -> pixel_on=0.
//    - DrawX=99 -> pixel_on=0.
//    - DrawX=131, rom_q=5 -> pixel_on=1, pal_index=5.
//  6 Edge: enemy_x=620, DrawX=639 -> hit, rom_addr low bits lx=19.
//    Coincident frame_start with enemy_active falling -> anim_frame=0.

Source files
------------

// File: rtl/running_enemy_sprite_fetch.sv
// Running-enemy sprite fetch: box test, run-cycle animation and ROM address generation
// with hit/colour-index alignment. Optional mirroring under RUNNING_ENEMY_FLIP_EN.
module running_enemy_sprite_fetch #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 48,
    parameter int NUM_FRAMES  = 6,
    parameter int FRAME_TICKS = 6,
    parameter int ROM_LATENCY = 1,
    localparam int ADDR_W     = $clog2(NUM_FRAMES*SPR_W*SPR_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              enemy_active,
    input  logic [9:0]        enemy_x,
    input  logic [9:0]        enemy_y,
    input  logic              facing_left,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_q,
    output logic [2:0]        pal_index,
    output logic              pixel_on,
    output logic [2:0]        anim_frame
);

    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [2:0]         LAST_FRAME = 3'(NUM_FRAMES - 1);
    localparam logic signed [10:0] SPR_W_S    = 11'(SPR_W);
    localparam logic signed [10:0] SPR_H_S    = 11'(SPR_H);
    localparam logic [ADDR_W-1:0]  FRAME_PIX  = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0]  ROW_PIX    = ADDR_W'(SPR_W);

    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [2:0]             anim_q, anim_d;
    logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
    logic [ROM_LATENCY:0]   hit_sr_q;
    logic [2:0]             pal_q, pal_d;
    logic                   pixel_on_q, pixel_on_d;

    logic signed [10:0]     lx_s0, ly_s0;
    logic [9:0]             col_s0;
    logic                   hit_s0;
    logic [ADDR_W-1:0]      addr_s0;

    // Animation: an inactive enemy pins the cycle to frame 0, even over a frame_start.
    always_comb begin
        tick_d = tick_q;
        anim_d = anim_q;
        if (!enemy_active) begin
            tick_d = '0;
            anim_d = '0;
        end else if (frame_start) begin
            if (tick_q == LAST_TICK) begin
                tick_d = '0;
                anim_d = (anim_q == LAST_FRAME) ? 3'd0 : anim_q + 3'd1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // Stage 0: sprite-local coordinates; the 11-bit signed difference rejects pixels left/above the box.
    assign lx_s0  = signed'({1'b0, DrawX}) - signed'({1'b0, enemy_x});
    assign ly_s0  = signed'({1'b0, DrawY}) - signed'({1'b0, enemy_y});
    assign hit_s0 = enemy_active
                  && (lx_s0 >= 11'sd0) && (lx_s0 < SPR_W_S)
                  && (ly_s0 >= 11'sd0) && (ly_s0 < SPR_H_S);

`ifdef RUNNING_ENEMY_FLIP_EN
    localparam logic [9:0] COL_LAST = 10'(SPR_W - 1);
    assign col_s0 = facing_left ? (COL_LAST - lx_s0[9:0]) : lx_s0[9:0];
`else
    logic unused_facing_left;
    assign unused_facing_left = facing_left;
    assign col_s0             = lx_s0[9:0];
`endif

    assign addr_s0 = ADDR_W'(anim_q) * FRAME_PIX
                   + ADDR_W'(ly_s0[9:0]) * ROW_PIX
                   + ADDR_W'(col_s0);

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (hit_s0) rom_addr_d = addr_s0;
    end

    // Output stage: hit has been delayed to line up with the ROM data for the same pixel.
    always_comb begin
        pal_d      = '0;
        pixel_on_d = 1'b0;
        if (hit_sr_q[ROM_LATENCY]) begin
            pal_d      = rom_q;
            pixel_on_d = (rom_q != 3'd0);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_q     <= '0;
            anim_q     <= '0;
            rom_addr_q <= '0;
            hit_sr_q   <= '0;
            pal_q      <= '0;
            pixel_on_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            anim_q     <= anim_d;
            rom_addr_q <= rom_addr_d;
            hit_sr_q   <= {hit_sr_q[ROM_LATENCY-1:0], hit_s0};
            pal_q      <= pal_d;
            pixel_on_q <= pixel_on_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pal_index  = pal_q;
    assign pixel_on   = pixel_on_q;
    assign anim_frame = anim_q;

endmodule

// File: tb/tb_running_enemy_sprite_fetch.sv
// Scoreboard bench for running_enemy_sprite_fetch at default parameters (ROM latency 1).
module tb_running_enemy_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        enemy_active;
    logic [9:0]  enemy_x, enemy_y;
    logic        facing_left;
    logic [9:0]  DrawX, DrawY;
    logic [13:0] rom_addr;
    logic [2:0]  rom_q;
    logic [2:0]  pal_index;
    logic        pixel_on;
    logic [2:0]  anim_frame;

`ifdef RUNNING_ENEMY_FLIP_EN
    localparam logic [13:0] FLIP_ADDR = 14'd122;
`else
    localparam logic [13:0] FLIP_ADDR = 14'd101;
`endif

    running_enemy_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .enemy_active(enemy_active),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .facing_left(facing_left),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_index(pal_index), .pixel_on(pixel_on), .anim_frame(anim_frame)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [14:0] addr_q[$];   // {check_enable, expected rom_addr}
    logic [3:0]  out_q[$];    // {expected pal_index, expected pixel_on}
    logic        pix_vld;
    logic        vld_p1, vld_p2, vld_p3;
    logic [2:0]  rq_d1, rq_d2;
    logic [9:0]  cfg_x, cfg_y;
    logic        cfg_act, cfg_face;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk or posedge Reset) begin
        if (Reset) {vld_p3, vld_p2, vld_p1} <= 3'b000;
        else       {vld_p3, vld_p2, vld_p1} <= {vld_p2, vld_p1, pix_vld};
    end

    // Monitor: address one cycle after the pixel, palette outputs three cycles after.
    always @(negedge Clk) begin
        logic [14:0] ea;
        logic [3:0]  eo;
        if (vld_p1) begin
            if (addr_q.size() == 0) chk("addr queue underflow", 1, 0);
            else begin
                ea = addr_q.pop_front();
                if (ea[14]) chk("rom_addr", rom_addr, ea[13:0]);
            end
        end
        if (vld_p3) begin
            if (out_q.size() == 0) chk("out queue underflow", 1, 0);
            else begin
                eo = out_q.pop_front();
                chk("pal_index", pal_index, eo[3:1]);
                chk("pixel_on", pixel_on, eo[0]);
            end
        end
    end

    // One pixel-clock of stimulus; rom_q carries the ROM word for the pixel issued two cycles earlier.
    task automatic step(input logic v, input logic [9:0] dx, input logic [9:0] dy,
                        input logic [2:0] rq, input logic fs, input logic ca,
                        input logic [13:0] ea, input logic [2:0] ep, input logic eo);
        @(posedge Clk); #1;
        enemy_x      = cfg_x;
        enemy_y      = cfg_y;
        enemy_active = cfg_act;
        facing_left  = cfg_face;
        DrawX        = dx;
        DrawY        = dy;
        frame_start  = fs;
        pix_vld      = v;
        rom_q        = rq_d2;
        rq_d2        = rq_d1;
        rq_d1        = rq;
        if (v) begin
            addr_q.push_back({ca, ea});
            out_q.push_back({ep, eo});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 14'd0, 3'd0, 1'b0);
    endtask

    task automatic pulses(input int n);
        repeat (n) step(1'b0, 10'd0, 10'd0, 3'd0, 1'b1, 1'b0, 14'd0, 3'd0, 1'b0);
        idle(1);
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; enemy_active = 1'b1; enemy_x = 10'd100; enemy_y = 10'd200;
        facing_left = 1'b0; DrawX = 10'd0; DrawY = 10'd0; rom_q = 3'd0; pix_vld = 1'b0;
        rq_d1 = 3'd0; rq_d2 = 3'd0;
        cfg_x = 10'd100; cfg_y = 10'd200; cfg_act = 1'b1; cfg_face = 1'b0;
        #3;
        chk("reset rom_addr", rom_addr, 0);
        chk("reset pal_index", pal_index, 0);
        chk("reset pixel_on", pixel_on, 0);
        chk("reset anim_frame", anim_frame, 0);
        #9 Reset = 1'b0;

        // Box, address and transparency at anim_frame 0
        step(1, 10'd105, 10'd203, 3'd5, 0, 1, 14'd101,  3'd5, 1);
        step(1, 10'd99,  10'd203, 3'd7, 0, 1, 14'd101,  3'd0, 0);
        step(1, 10'd110, 10'd210, 3'd0, 0, 1, 14'd330,  3'd0, 0);
        step(1, 10'd132, 10'd200, 3'd7, 0, 1, 14'd330,  3'd0, 0);
        step(1, 10'd131, 10'd200, 3'd5, 0, 1, 14'd31,   3'd5, 1);
        step(1, 10'd100, 10'd247, 3'd1, 0, 1, 14'd1504, 3'd1, 1);
        step(1, 10'd100, 10'd248, 3'd7, 0, 1, 14'd1504, 3'd0, 0);
        step(1, 10'd100, 10'd199, 3'd7, 0, 1, 14'd1504, 3'd0, 0);
        cfg_face = 1'b1;
        step(1, 10'd105, 10'd203, 3'd5, 0, 1, FLIP_ADDR, 3'd5, 1);
        cfg_face = 1'b0;
        idle(4);

        // Animation stepping and wrap
        pulses(12);
        chk("anim after 12 pulses", anim_frame, 2);
        step(1, 10'd100, 10'd200, 3'd3, 0, 1, 14'd3072, 3'd3, 1);
        idle(4);
        cfg_act = 1'b0;
        step(1, 10'd105, 10'd203, 3'd5, 0, 0, 14'd0, 3'd0, 0);
        idle(1);
        chk("anim inactive", anim_frame, 0);
        cfg_act = 1'b1;
        pulses(30);
        chk("anim after 30 pulses", anim_frame, 5);
        pulses(6);
        chk("anim wrap after 36", anim_frame, 0);

        // Inactive enemy overrides a coincident frame_start and clears the tick count
        pulses(6);
        pulses(5);
        chk("anim before drop", anim_frame, 1);
        cfg_act = 1'b0;
        step(0, 10'd0, 10'd0, 3'd0, 1, 0, 14'd0, 3'd0, 0);
        cfg_act = 1'b1;
        idle(1);
        chk("anim drop with frame_start", anim_frame, 0);
        pulses(5);
        chk("tick cleared by drop", anim_frame, 0);
        pulses(1);
        chk("anim after 6th pulse", anim_frame, 1);

        // Right screen edge, anim_frame 1
        cfg_x = 10'd620;
        step(1, 10'd639, 10'd200, 3'd6, 0, 1, 14'd1555, 3'd6, 1);
        step(1, 10'd0,   10'd200, 3'd7, 0, 1, 14'd1555, 3'd0, 0);
        idle(4);

        // Asynchronous reset mid-stream, then refill
        cfg_x = 10'd100;
        step(1, 10'd105, 10'd203, 3'd5, 0, 1, 14'd1637, 3'd5, 1);
        #2 Reset = 1'b1;
        #1;
        chk("midline reset rom_addr", rom_addr, 0);
        chk("midline reset pal_index", pal_index, 0);
        chk("midline reset pixel_on", pixel_on, 0);
        chk("midline reset anim_frame", anim_frame, 0);
        addr_q.delete();
        out_q.delete();
        pix_vld = 1'b0;
        rq_d1 = 3'd0;
        rq_d2 = 3'd0;
        #2 Reset = 1'b0;
        step(1, 10'd105, 10'd203, 3'd5, 0, 1, 14'd101, 3'd5, 1);
        idle(5);
        chk("scoreboard drained", addr_q.size() + out_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
